// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions.
//
// Contents:
//   ADDR_W        byte-address width of the PC and the instruction memory
//   INST_W        instruction width
//   BR_OFF_W      width of the signed word offset carried by B/CBZ redirects
//   HALT_WORD     the all-zero word that ends a program
//   fetch_state_t fetch-stage state encoding (RUN=0, HALTED=1)
package legv8_pkg;

    localparam int ADDR_W   = 12;
    localparam int INST_W   = 32;
    localparam int BR_OFF_W = 26;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage : legv8_pkg

// File: rtl/branch_target_adder.sv
// Branch target adder.
//
// Combinational: target = {base_pc[ADDR_W-1:2], 2'b00} + (sext(offset) << 2),
// computed modulo 2^ADDR_W. Shared by the fetch-stage redirect path and the
// execute-stage branch unit.
//
// Ports:
//   base_pc  in  ADDR_W    PC of the branch instruction (low two bits ignored)
//   offset   in  OFF_W     signed word offset
//   target   out ADDR_W    word-aligned branch target
module branch_target_adder #(
    parameter int ADDR_W = legv8_pkg::ADDR_W,
    parameter int OFF_W  = legv8_pkg::BR_OFF_W
) (
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] aligned_base;
    logic [ADDR_W-1:0] byte_offset;

    // Clear the low bits by masking so a misaligned branch PC cannot leak
    // into the target.
    assign aligned_base = base_pc & ~ADDR_W'(3);

    // Sign-extend to well beyond ADDR_W, append the x4 shift, then keep the
    // low ADDR_W bits. Works whether ADDR_W is narrower or wider than the
    // shifted offset; the truncation is the modulo-2^ADDR_W wrap.
    assign byte_offset = ADDR_W'({{ADDR_W{offset[OFF_W-1]}}, offset, 2'b00});

    assign target = aligned_base + byte_offset;

endmodule : branch_target_adder

// File: rtl/instruction_fetch_unit.sv
// LEGv8 instruction fetch unit.
//
// Owns the program counter, drives the instruction-memory byte address,
// captures the returned word into the IF/ID register and hands it to decode.
// Handles branch redirects, decode back-pressure and halt on an all-zero word.
//
// Handshake: if_valid/id_ready follow strict valid/ready rules. A transfer
// happens on a rising edge where if_valid && id_ready. While if_valid is high
// and id_ready is low, if_inst and if_pc hold their values. if_valid never
// depends combinationally on id_ready. A redirect may drop if_valid at any
// time (wrong-path flush), which is the only way valid falls without a
// transfer.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   pc_addr      out  byte address to instruction memory (the PC register)
//   inst_in      in   word at pc_addr, combinational from memory
//   br_valid     in   redirect request, one-cycle pulse
//   br_pc        in   PC of the branch instruction
//   br_offset    in   signed word offset of the branch
//   if_valid     out  IF/ID register holds a valid instruction
//   if_inst      out  captured instruction
//   if_pc        out  PC of if_inst
//   id_ready     in   decode accepts if_inst this cycle
//   halted       out  fetch has stopped on a halt word
//   fetch_state  out  current fetch state, for observation
module instruction_fetch_unit
    import legv8_pkg::fetch_state_t, legv8_pkg::RUN, legv8_pkg::HALTED,
           legv8_pkg::HALT_WORD;
#(
    parameter int                ADDR_W   = legv8_pkg::ADDR_W,
    parameter int                INST_W   = legv8_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [ADDR_W-1:0]           pc_addr,
    input  logic [INST_W-1:0]           inst_in,
    input  logic                        br_valid,
    input  logic [ADDR_W-1:0]           br_pc,
    input  logic [legv8_pkg::BR_OFF_W-1:0] br_offset,
    output logic                        if_valid,
    output logic [INST_W-1:0]           if_inst,
    output logic [ADDR_W-1:0]           if_pc,
    input  logic                        id_ready,
    output logic                        halted,
    output fetch_state_t                fetch_state
);

    // The PC is always word aligned, including straight out of reset.
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    fetch_state_t      state_q;
    logic              if_valid_q;
    logic [INST_W-1:0] if_inst_q;
    logic [ADDR_W-1:0] if_pc_q;
    logic              halted_q;

    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_seq;
    logic              slot_free;
    logic              is_halt_word;

    branch_target_adder #(
        .ADDR_W (ADDR_W),
        .OFF_W  (legv8_pkg::BR_OFF_W)
    ) u_br_adder (
        .base_pc (br_pc),
        .offset  (br_offset),
        .target  (br_target)
    );

    // Sequential next PC; the adder width makes 0xFFC + 4 wrap to 0x000.
    assign pc_seq = pc_q + ADDR_W'(4);

    // The IF/ID slot can be refilled when it is empty or being drained now.
    assign slot_free = !if_valid_q || id_ready;

    assign is_halt_word = (inst_in == INST_W'(HALT_WORD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC_ALIGNED;
            state_q    <= RUN;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else if (br_valid) begin
            // Redirect outranks stall and halt in every state. The slot is
            // flushed because whatever it holds came from the wrong path;
            // if_inst/if_pc keep their old contents but are no longer valid.
            pc_q       <= br_target;
            if_valid_q <= 1'b0;
            state_q    <= RUN;
            halted_q   <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (slot_free) begin
                        if (is_halt_word) begin
                            // PC parks on the halt word; nothing is issued.
                            if_valid_q <= 1'b0;
                            state_q    <= HALTED;
                            halted_q   <= 1'b1;
                        end else begin
                            if_inst_q  <= inst_in;
                            if_pc_q    <= pc_q;
                            if_valid_q <= 1'b1;
                            pc_q       <= pc_seq;
                        end
                    end
                    // Slot busy: everything holds and memory is re-read at
                    // the same address next cycle.
                end
                HALTED: begin
                    if_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc_addr     = pc_q;
    assign if_valid    = if_valid_q;
    assign if_inst     = if_inst_q;
    assign if_pc       = if_pc_q;
    assign halted      = halted_q;
    assign fetch_state = state_q;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;

    // Main instance, RESET_PC = 0
    logic [11:0] pc_addr;
    logic [31:0] inst_in;
    logic        br_valid;
    logic [11:0] br_pc;
    logic [25:0] br_offset;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [11:0] if_pc;
    logic        id_ready;
    logic        halted;
    legv8_pkg::fetch_state_t fetch_state;

    // Wrap instance, RESET_PC = 0xFFC
    logic [11:0] pc_addr_w;
    logic [31:0] inst_in_w;
    logic        if_valid_w;
    logic [31:0] if_inst_w;
    logic [11:0] if_pc_w;
    logic        halted_w;
    legv8_pkg::fetch_state_t fetch_state_w;

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_read(input logic [11:0] a);
        case (a)
            12'h000: mem_read = 32'h8B02_0020;
            12'h004: mem_read = 32'hCB03_0041;
            12'h008: mem_read = 32'h17FF_FFFE;
            12'h00C: mem_read = 32'h0000_0000;
            12'hFFC: mem_read = 32'h9100_0421;
            default: mem_read = 32'h0000_0000;
        endcase
    endfunction

    assign inst_in   = mem_read(pc_addr);
    assign inst_in_w = mem_read(pc_addr_w);

    instruction_fetch_unit #(
        .ADDR_W(12), .INST_W(32), .RESET_PC(12'h000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .inst_in(inst_in),
        .br_valid(br_valid), .br_pc(br_pc), .br_offset(br_offset),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .halted(halted), .fetch_state(fetch_state)
    );

    instruction_fetch_unit #(
        .ADDR_W(12), .INST_W(32), .RESET_PC(12'hFFC)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr_w), .inst_in(inst_in_w),
        .br_valid(1'b0), .br_pc(12'h000), .br_offset(26'h0),
        .if_valid(if_valid_w), .if_inst(if_inst_w), .if_pc(if_pc_w),
        .id_ready(1'b1), .halted(halted_w), .fetch_state(fetch_state_w)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic [11:0] bpc;
        logic [25:0] boff;
        logic [11:0] e_pc;
        logic        e_v;
        logic [31:0] e_inst;
        logic [11:0] e_ifpc;
        logic        e_halt;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_pc     = 12'h000;
        br_offset = 26'h0;
        id_ready  = 1'b1;

        //            rdy   br    bpc      boff          pc       v     inst           ifpc     halt
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h004, 1'b1, 32'h8B020020, 12'h000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b1, 32'h17FFFFFE, 12'h008, 1'b0};
        // redirect 008 + (-2*4) = 000
        vecs[6]  = '{1'b1, 1'b1, 12'h008, 26'h3FFFFFE,  12'h000, 1'b0, 32'h17FFFFFE, 12'h008, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h004, 1'b1, 32'h8B020020, 12'h000, 1'b0};
        // redirect while valid and not ready: 000 + 4 = 004, slot flushed
        vecs[8]  = '{1'b0, 1'b1, 12'h000, 26'h0000001,  12'h004, 1'b0, 32'h8B020020, 12'h000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b1, 32'h17FFFFFE, 12'h008, 1'b0};
        // halt word at 00C
        vecs[11] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b0, 32'h17FFFFFE, 12'h008, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b0, 32'h17FFFFFE, 12'h008, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b0, 32'h17FFFFFE, 12'h008, 1'b1};
        // exit halt: 00C + (-3*4) = 000
        vecs[14] = '{1'b1, 1'b1, 12'h00C, 26'h3FFFFFD,  12'h000, 1'b0, 32'h17FFFFFE, 12'h008, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h004, 1'b1, 32'h8B020020, 12'h000, 1'b0};
        // target wrap: 000 + (-1*4) = FFC, then PC+4 wraps to 000
        vecs[16] = '{1'b1, 1'b1, 12'h000, 26'h3FFFFFF,  12'hFFC, 1'b0, 32'h8B020020, 12'h000, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h000, 1'b1, 32'h91000421, 12'hFFC, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h004, 1'b1, 32'h8B020020, 12'h000, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h008, 1'b1, 32'hCB030041, 12'h004, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b1, 32'h17FFFFFE, 12'h008, 1'b0};
        // halt word present but slot busy: stall, no halt yet
        vecs[21] = '{1'b0, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b1, 32'h17FFFFFE, 12'h008, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b0, 32'h17FFFFFE, 12'h008, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 12'h000, 26'h0,        12'h00C, 1'b0, 32'h17FFFFFE, 12'h008, 1'b1};

        // Reset values, held in reset across a clock edge
        repeat (2) @(posedge clk);
        #1;
        check("rst pc_addr",   32'(pc_addr),     32'h000);
        check("rst if_valid",  32'(if_valid),    32'h0);
        check("rst if_inst",   if_inst,          32'h0);
        check("rst if_pc",     32'(if_pc),       32'h000);
        check("rst halted",    32'(halted),      32'h0);
        check("rst state",     32'(fetch_state), 32'h0);
        check("rst pc_addr_w", 32'(pc_addr_w),   32'hFFC);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            id_ready  = vecs[i].rdy;
            br_valid  = vecs[i].br;
            br_pc     = vecs[i].bpc;
            br_offset = vecs[i].boff;
            @(posedge clk);
            #1;
            check($sformatf("row%0d pc_addr", i),  32'(pc_addr),     32'(vecs[i].e_pc));
            check($sformatf("row%0d if_valid", i), 32'(if_valid),    32'(vecs[i].e_v));
            check($sformatf("row%0d if_inst", i),  if_inst,          vecs[i].e_inst);
            check($sformatf("row%0d if_pc", i),    32'(if_pc),       32'(vecs[i].e_ifpc));
            check($sformatf("row%0d halted", i),   32'(halted),      32'(vecs[i].e_halt));
            check($sformatf("row%0d state", i),    32'(fetch_state), 32'(vecs[i].e_halt));
            // Row 0 is the first fetch of both instances: RESET_PC=FFC wraps.
            if (i == 0) begin
                check("wrap pc_addr_w",  32'(pc_addr_w),  32'h000);
                check("wrap if_pc_w",    32'(if_pc_w),    32'hFFC);
                check("wrap if_inst_w",  if_inst_w,       32'h91000421);
                check("wrap if_valid_w", 32'(if_valid_w), 32'h1);
            end
            @(negedge clk);
        end

        // Async reset mid-cycle while halted with stale IF/ID contents
        br_valid = 1'b0;
        id_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async pc_addr",   32'(pc_addr),     32'h000);
        check("async if_valid",  32'(if_valid),    32'h0);
        check("async if_inst",   if_inst,          32'h0);
        check("async if_pc",     32'(if_pc),       32'h000);
        check("async halted",    32'(halted),      32'h0);
        check("async state",     32'(fetch_state), 32'h0);
        check("async pc_addr_w", 32'(pc_addr_w),   32'hFFC);
        check("async halted_w",  32'(halted_w),    32'h0);

        // Release and fetch once more from both reset PCs
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel pc_addr",    32'(pc_addr),   32'h004);
        check("rel if_pc",      32'(if_pc),     32'h000);
        check("rel if_inst",    if_inst,        32'h8B020020);
        check("rel pc_addr_w",  32'(pc_addr_w), 32'h000);
        check("rel if_pc_w",    32'(if_pc_w),   32'hFFC);
        check("rel if_inst_w",  if_inst_w,      32'h91000421);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage front end of the LEGv8 single-issue pipeline. It owns the program counter and drives the byte address into `instructionMemory`. It captures the returned 32-bit word into an IF/ID output register and presents it to decode through a valid/ready handshake. It also handles branch redirects, decode back-pressure, and end-of-program halt.

## Interface
Parameters:
- `ADDR_W`, 12: PC / instruction-memory byte-address width.
- `INST_W`, 32: instruction width.
- `RESET_PC`, 12'h000: PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pc_addr`  out  ADDR_W  byte address to instruction memory; equals the PC register.
- `inst_in`  in  INST_W  word returned by instruction memory for `pc_addr` (combinational, same cycle).
- `br_valid`  in  1  redirect request from decode/execute, single-cycle pulse.
- `br_pc`  in  ADDR_W  PC of the branch instruction.
- `br_offset`  in  26  signed word offset (B/CBZ imm, already selected by decode).
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_inst`  out  INST_W  captured instruction.
- `if_pc`  out  ADDR_W  PC of `if_inst`.
- `id_ready`  in  1  decode accepts `if_inst` this cycle.
- `halted`  out  1  fetch stopped on a halt word.

## Operation
- States: RUN, HALTED. Reset state is RUN.
- Slot free: `!if_valid || id_ready`.
- RUN, no redirect, slot free, `inst_in != 32'h0000_0000`:
  - `if_inst <= inst_in`, `if_pc <= pc_addr`, `if_valid <= 1`.
  - `PC <= PC + 4`.
- RUN, slot free, `inst_in == 32'h0` (halt word):
  - `if_valid <= 0`; PC holds.
  - State goes to HALTED and `halted <= 1`.
- RUN, slot not free: IF/ID register and PC hold (stall). Memory is re-read at the same address.
- HALTED: PC holds, `if_valid` stays 0. This is exited only by a redirect.
- Redirect (`br_valid`): highest priority in any state, and wins over stall and halt.
  - Target = `{br_pc[ADDR_W-1:2],2'b00} + (sext(br_offset) << 2)`, truncated to ADDR_W.
  - `PC <= target`; `if_valid <= 0` (flushes the wrong-path slot).
  - State goes to RUN and `halted <= 0`.
- Arithmetic: all PC math is modulo 2^ADDR_W. PC+4 from 12'hFFC wraps to 12'h000. The target wraps the same way.
- PC bits [1:0] are always 0. `RESET_PC` low bits are forced to 0.

## Timing
- Reset values: PC = `RESET_PC`, `pc_addr` = `RESET_PC`, `if_valid` = 0, `if_inst` = 0, `if_pc` = 0, `halted` = 0, state = RUN.
- Reset is asynchronous. Asserting it mid-stall or mid-redirect discards everything in flight.
- Fetch latency is 1 cycle from `pc_addr` to `if_valid`/`if_inst`. Steady-state throughput is 1 instruction/cycle when `id_ready` is held high.
- Redirect penalty:
  - Cycle N: `br_valid` is high.
  - Cycle N+1: `pc_addr` = target and `if_valid` = 0.
  - Cycle N+2: the target instruction is valid.
- Handshake: a transfer occurs on an edge where `if_valid && id_ready`. While `if_valid && !id_ready`, `if_inst`/`if_pc` stay stable.
- `id_ready` has no effect on halt detection timing beyond the slot-free rule.
- Simultaneous redirect and `id_ready` low: the redirect wins and the stalled slot is flushed.

## Structure
- Shared package `legv8_pkg`: `ADDR_W`, `INST_W`, `HALT_WORD` (32'h0), fetch state encoding (RUN=0, HALTED=1).
- Sub-module `branch_target_adder` does the combinational sign-extend, shift-by-2 and ADDR_W add. It is reused later by the execute-stage branch unit.
- The top level holds the PC register, the state register, the IF/ID register and the next-PC mux.

## Test plan
Bench memory: 0x000=8B020020, 0x004=CB030041, 0x008=17FFFFFE (B -2), 0x00C=00000000.
- **Sequential fetch.** Stimulus: reset, release, `id_ready`=1. Required: `if_pc` goes 000, 004, 008 on consecutive cycles, with `if_inst` matching memory. `pc_addr` leads `if_pc` by 1 cycle.
- **Stall.** Stimulus: hold `id_ready`=0 for 3 cycles while `if_pc`=004. Required: `if_inst`=CB030041 stable, `pc_addr`=008 held. Fetch resumes with 008 one cycle after `id_ready` rises.
- **Redirect.** Stimulus: pulse `br_valid` with `br_pc`=008, `br_offset`=-2. Required: next cycle `pc_addr`=000 and `if_valid`=0; the following cycle `if_pc`=000.
- **Redirect beats stall.** Stimulus: `br_valid` while `if_valid`=1 and `id_ready`=0. Required: slot flushed (`if_valid`=0) and PC = target.
- **Halt.** Stimulus: fetch reaches 0x00C. Required: `halted`=1, `if_valid`=0, `pc_addr` stuck at 00C. A later `br_valid` with `br_pc`=00C, `br_offset`=-3 gives `pc_addr`=000 and `halted`=0.
- **Wrap and async reset.** Stimulus: `RESET_PC`=12'hFFC with a non-zero word there. Required: the next `pc_addr` is 000. Then drop `rst_n` mid-cycle. Required: all outputs go to their reset values immediately, without waiting for a clock edge.
